// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard sense inputs and stage control outputs
interface hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] ID_rs1;
  logic [REG_W-1:0] ID_rs2;
  logic             ID_useRs1;
  logic             ID_useRs2;
  logic             EX_MemRead;
  logic [REG_W-1:0] EX_rd;
  logic             EX_redirect;
  logic             imem_ready;
  logic             MEM_MemAccess;
  logic             dmem_ready;

  logic             PCWrite;
  logic             PCSel;
  logic             IF_IDWrite;
  logic             IF_IDFlush;
  logic             ID_EXWrite;
  logic             ID_EXFlush;
  logic             EX_MEMWrite;
  logic             MEM_WBFlush;

  modport master (
    input  ID_rs1, ID_rs2, ID_useRs1, ID_useRs2, EX_MemRead, EX_rd,
           EX_redirect, imem_ready, MEM_MemAccess, dmem_ready,
    output PCWrite, PCSel, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush,
           EX_MEMWrite, MEM_WBFlush
  );

  modport slave (
    output ID_rs1, ID_rs2, ID_useRs1, ID_useRs2, EX_MemRead, EX_rd,
           EX_redirect, imem_ready, MEM_MemAccess, dmem_ready,
    input  PCWrite, PCSel, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush,
           EX_MEMWrite, MEM_WBFlush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline sequencer: stalls, flushes, redirects, stale-fetch discard
module hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.master    hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, DISCARD} state_t;

  state_t state, state_nxt;

  logic dstall, luse, ifv;
  logic pc_write, pc_sel, ifid_write, ifid_flush;
  logic idex_write, idex_flush, exmem_write, memwb_flush;
  logic flush_inc;

  assign dstall = hz.MEM_MemAccess & ~hz.dmem_ready;
  assign luse   = hz.EX_MemRead & (hz.EX_rd != {REG_W{1'b0}}) &
                  ((hz.ID_useRs1 & (hz.ID_rs1 == hz.EX_rd)) |
                   (hz.ID_useRs2 & (hz.ID_rs2 == hz.EX_rd)));
  assign ifv    = hz.imem_ready & (state == RUN);

  always_comb begin
    pc_write    = 1'b1;
    pc_sel      = 1'b0;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    memwb_flush = 1'b0;
    flush_inc   = 1'b0;
    state_nxt   = state;

    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_nxt   = RUN;
    end else if (dstall) begin
      // Whole front end freezes; a pending redirect is re-presented next cycle.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else if (hz.EX_redirect) begin
      pc_sel     = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
      state_nxt  = (state == DISCARD || !hz.imem_ready) ? DISCARD : RUN;
    end else begin
      // The word returning in DISCARD is the stale pre-redirect fetch.
      if (state == DISCARD && hz.imem_ready)
        state_nxt = RUN;
      if (luse) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end else if (!ifv) begin
        pc_write   = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  assign hz.PCWrite     = pc_write;
  assign hz.PCSel       = pc_sel;
  assign hz.IF_IDWrite  = ifid_write;
  assign hz.IF_IDFlush  = ifid_flush;
  assign hz.ID_EXWrite  = idex_write;
  assign hz.ID_EXFlush  = idex_flush;
  assign hz.EX_MEMWrite = exmem_write;
  assign hz.MEM_WBFlush = memwb_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!pc_write && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush_inc && flush_cnt != {CNT_W{1'b1}})
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam logic [7:0] C_RUN   = 8'b1010_1010;
  localparam logic [7:0] C_RST   = 8'b0000_0000;
  localparam logic [7:0] C_LUSE  = 8'b0000_1110;
  localparam logic [7:0] C_REDIR = 8'b1111_1110;
  localparam logic [7:0] C_BUB   = 8'b0011_1010;
  localparam logic [7:0] C_FRZ   = 8'b0000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_s;
  logic [31:0] stall_cnt, flush_cnt;
  logic [3:0]  stall_cnt_s, flush_cnt_s;
  logic [7:0]  ctl;
  int          checks = 0;
  int          errors = 0;

  hazard_ctrl_if #(.REG_W(5)) bus ();
  hazard_ctrl_if #(.REG_W(5)) bus_s ();

  hazard_ctrl #(.CNT_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(rst), .hz(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4), .REG_W(5)) dut_sat (
    .clk(clk), .reset(rst_s), .hz(bus_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  assign ctl = {bus.PCWrite, bus.PCSel, bus.IF_IDWrite, bus.IF_IDFlush,
                bus.ID_EXWrite, bus.ID_EXFlush, bus.EX_MEMWrite, bus.MEM_WBFlush};

  always #5 clk = ~clk;

  task automatic set_idle;
    bus.ID_rs1 = 5'd1; bus.ID_rs2 = 5'd2; bus.ID_useRs1 = 1'b1; bus.ID_useRs2 = 1'b1;
    bus.EX_MemRead = 1'b0; bus.EX_rd = 5'd3; bus.EX_redirect = 1'b0;
    bus.imem_ready = 1'b1; bus.MEM_MemAccess = 1'b0; bus.dmem_ready = 1'b1;
  endtask

  task automatic do_reset;
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    set_idle();
    rst = 1'b1;
    #1;
    checks++; if (ctl !== C_RST) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RST); end
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL run_ctl got=%b exp=%b", ctl, C_RUN); end
    @(negedge clk);
  endtask

  task automatic test_load_use;
    do_reset();
    bus.EX_MemRead = 1'b1; bus.EX_rd = 5'd5; bus.ID_rs1 = 5'd5;
    #1;
    checks++; if (ctl !== C_LUSE) begin errors++; $display("FAIL luse_ctl got=%b exp=%b", ctl, C_LUSE); end
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL luse_stall_cnt got=%0d exp=1", stall_cnt); end
    set_idle();
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL luse_one_cycle got=%b exp=%b", ctl, C_RUN); end
    @(negedge clk);
    bus.EX_MemRead = 1'b1; bus.EX_rd = 5'd0; bus.ID_rs1 = 5'd0; bus.ID_rs2 = 5'd0;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL luse_x0_ctl got=%b exp=%b", ctl, C_RUN); end
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL luse_x0_stall_cnt got=%0d exp=1", stall_cnt); end
    // rs2 path also triggers the stall
    bus.EX_rd = 5'd7; bus.ID_rs2 = 5'd7; bus.ID_rs1 = 5'd1;
    #1;
    checks++; if (ctl !== C_LUSE) begin errors++; $display("FAIL luse_rs2_ctl got=%b exp=%b", ctl, C_LUSE); end
    @(negedge clk);
  endtask

  task automatic test_redirect_ready;
    do_reset();
    bus.EX_redirect = 1'b1;
    bus.EX_MemRead = 1'b1; bus.EX_rd = 5'd1;
    #1;
    checks++; if (ctl !== C_REDIR) begin errors++; $display("FAIL redir_ctl got=%b exp=%b", ctl, C_REDIR); end
    @(negedge clk);
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL redir_flush_cnt got=%0d exp=1", flush_cnt); end
    set_idle();
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL redir_stays_run got=%b exp=%b", ctl, C_RUN); end
    @(negedge clk);
  endtask

  task automatic test_redirect_outstanding;
    do_reset();
    bus.EX_redirect = 1'b1; bus.imem_ready = 1'b0;
    #1;
    checks++; if (ctl !== C_REDIR) begin errors++; $display("FAIL outst_redir_ctl got=%b exp=%b", ctl, C_REDIR); end
    @(negedge clk);
    set_idle();
    #1;
    checks++; if (ctl !== C_BUB) begin errors++; $display("FAIL outst_stale_bubble got=%b exp=%b", ctl, C_BUB); end
    @(negedge clk);
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL outst_resume got=%b exp=%b", ctl, C_RUN); end
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL outst_stall_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_dmem_freeze;
    do_reset();
    bus.MEM_MemAccess = 1'b1; bus.dmem_ready = 1'b0; bus.EX_redirect = 1'b1;
    bus.EX_MemRead = 1'b1; bus.EX_rd = 5'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL freeze_ctl cyc=%0d got=%b exp=%b", i, ctl, C_FRZ); end
      @(negedge clk);
    end
    bus.dmem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_REDIR) begin errors++; $display("FAIL freeze_then_redir got=%b exp=%b", ctl, C_REDIR); end
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL freeze_stall_cnt got=%0d exp=3", stall_cnt); end
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL freeze_flush_cnt got=%0d exp=1", flush_cnt); end
    set_idle();
  endtask

  task automatic test_back_to_back;
    do_reset();
    bus.EX_redirect = 1'b1; bus.imem_ready = 1'b0;
    @(negedge clk);
    // dstall in DISCARD must hold the state, so the stale word is still dropped after
    set_idle();
    bus.MEM_MemAccess = 1'b1; bus.dmem_ready = 1'b0;
    #1;
    checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL b2b_freeze got=%b exp=%b", ctl, C_FRZ); end
    @(negedge clk);
    set_idle();
    #1;
    checks++; if (ctl !== C_BUB) begin errors++; $display("FAIL b2b_bubble got=%b exp=%b", ctl, C_BUB); end
    @(negedge clk);
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL b2b_resume got=%b exp=%b", ctl, C_RUN); end
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL b2b_stall_cnt got=%0d exp=2", stall_cnt); end
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL b2b_flush_cnt got=%0d exp=1", flush_cnt); end
  endtask

  task automatic test_reset_in_discard;
    do_reset();
    bus.EX_redirect = 1'b1; bus.imem_ready = 1'b0;
    @(negedge clk);
    set_idle();
    bus.imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (ctl !== C_RST) begin errors++; $display("FAIL rstdisc_ctl got=%b exp=%b", ctl, C_RST); end
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rstdisc_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL rstdisc_flush_cnt got=%0d exp=0", flush_cnt); end
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL rstdisc_no_bubble got=%b exp=%b", ctl, C_RUN); end
    @(negedge clk);
  endtask

  task automatic test_saturation;
    bus_s.imem_ready = 1'b0;
    rst_s = 1'b0;
    #1;
    checks++; if (bus_s.PCWrite !== 1'b0) begin errors++; $display("FAIL sat_pcwrite got=%b exp=0", bus_s.PCWrite); end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 14) begin
        checks++; if (stall_cnt_s !== 4'd14) begin errors++; $display("FAIL sat_cnt14 got=%0d exp=14", stall_cnt_s); end
      end
      if (i == 15) begin
        checks++; if (stall_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_cnt15 got=%0d exp=15", stall_cnt_s); end
      end
    end
    checks++; if (stall_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt_s); end
  endtask

  initial begin
    rst = 1'b1;
    rst_s = 1'b1;
    set_idle();
    bus_s.ID_rs1 = 5'd1; bus_s.ID_rs2 = 5'd2; bus_s.ID_useRs1 = 1'b0; bus_s.ID_useRs2 = 1'b0;
    bus_s.EX_MemRead = 1'b0; bus_s.EX_rd = 5'd3; bus_s.EX_redirect = 1'b0;
    bus_s.imem_ready = 1'b1; bus_s.MEM_MemAccess = 1'b0; bus_s.dmem_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_redirect_ready();
    test_redirect_outstanding();
    test_dmem_freeze();
    test_back_to_back();
    test_reset_in_discard();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
